melody_sequencer: RTL and testbench



---
 rtl/melody_pkg.sv | 29 ++
 rtl/melody_rom.sv | 27 ++
 rtl/melody_sequencer.sv | 181 ++++++++++++++++++
 tb/tb_melody_sequencer.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/melody_pkg.sv
// Shared types and ROM word layout for the melody sequencer.
// A ROM word is {note[5:0], dur[3:0]}; dur == 0 marks the end of a song.
package melody_pkg;

    localparam int unsigned NOTE_W = 6;
    localparam int unsigned DUR_W  = 4;
    localparam int unsigned WORD_W = NOTE_W + DUR_W;

    localparam logic [NOTE_W-1:0] NOTE_REST = '0;
    localparam logic [DUR_W-1:0]  DUR_END   = '0;

    typedef enum logic [2:0] {
        StIdle,
        StFetch,
        StLoad,
        StPlay,
        StGap,
        StEnd
    } state_e;

    function automatic logic [NOTE_W-1:0] word_note(input logic [WORD_W-1:0] w);
        return w[WORD_W-1:DUR_W];
    endfunction

    function automatic logic [DUR_W-1:0] word_dur(input logic [WORD_W-1:0] w);
        return w[DUR_W-1:0];
    endfunction

endpackage

// File: rtl/melody_rom.sv
// Synchronous-read song ROM, addressed as {song, index}; data appears one cycle after the address.
// Contents come from the INIT image (entry k occupies bits [k*WORD_W +: WORD_W]).
module melody_rom
    import melody_pkg::*;
#(
    parameter int unsigned SONGS  = 4,
    parameter int unsigned ADDR_W = 6,
    parameter int unsigned SONG_W = 2,
    parameter logic [SONGS*(2**ADDR_W)*WORD_W-1:0] INIT = '0
) (
    input  logic                     clk,
    input  logic [SONG_W+ADDR_W-1:0] addr,
    output logic [WORD_W-1:0]        word
);

    localparam int unsigned DEPTH = SONGS * (2 ** ADDR_W);

    // Addresses beyond the populated songs read as an end marker.
    always_ff @(posedge clk) begin
        if (32'(addr) < DEPTH) begin
            word <= INIT[32'(addr) * WORD_W +: WORD_W];
        end else begin
            word <= '0;
        end
    end

endmodule

// File: rtl/melody_sequencer.sv
// Plays (note, duration) entries from the song ROM, holding each note for dur ticks
// and forcing a silent gap between notes for articulation.
module melody_sequencer
    import melody_pkg::*;
#(
    parameter int unsigned TICK_CYCLES = 1_562_500,
    parameter int unsigned GAP_CYCLES  = 1_000_000,
    parameter int unsigned SONGS       = 4,
    parameter int unsigned ADDR_W      = 6,
    parameter int unsigned SONG_W      = (SONGS > 1) ? $clog2(SONGS) : 1,
    parameter logic [SONGS*(2**ADDR_W)*WORD_W-1:0] ROM_INIT = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              stop,
    input  logic [SONG_W-1:0] song_sel,
    input  logic              loop,
    output logic [NOTE_W-1:0] note,
    output logic              busy,
    output logic              done
);

    // One counter serves both the tick prescaler and the gap timer.
    localparam int unsigned CNT_MAX = (TICK_CYCLES > GAP_CYCLES) ? TICK_CYCLES : GAP_CYCLES;
    localparam int unsigned CNT_W   = (CNT_MAX > 2) ? $clog2(CNT_MAX) : 1;
    localparam logic [CNT_W-1:0]  TICK_LAST = CNT_W'(TICK_CYCLES - 1);
    localparam logic [CNT_W-1:0]  GAP_LAST  = CNT_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
    localparam logic [ADDR_W-1:0] ADDR_LAST = '1;

    state_e              state_q, state_d;
    logic [SONG_W-1:0]   song_q, song_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [CNT_W-1:0]    cyc_q, cyc_d;
    logic [DUR_W-1:0]    tick_q, tick_d;
    logic [DUR_W-1:0]    dur_q, dur_d;
    logic [NOTE_W-1:0]   note_q, note_d;
    logic                done_q, done_d;

    logic [WORD_W-1:0]   rom_word;
    logic [DUR_W-1:0]    dur_last;
    logic                do_advance;
    logic                enter_end;

    melody_rom #(
        .SONGS  (SONGS),
        .ADDR_W (ADDR_W),
        .SONG_W (SONG_W),
        .INIT   (ROM_INIT)
    ) u_rom (
        .clk  (clk),
        .addr ({song_q, addr_q}),
        .word (rom_word)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            song_q  <= '0;
            addr_q  <= '0;
            cyc_q   <= '0;
            tick_q  <= '0;
            dur_q   <= '0;
            note_q  <= NOTE_REST;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            song_q  <= song_d;
            addr_q  <= addr_d;
            cyc_q   <= cyc_d;
            tick_q  <= tick_d;
            dur_q   <= dur_d;
            note_q  <= note_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        song_d     = song_q;
        addr_d     = addr_q;
        cyc_d      = cyc_q;
        tick_d     = tick_q;
        dur_d      = dur_q;
        note_d     = note_q;
        done_d     = 1'b0;
        do_advance = 1'b0;
        enter_end  = 1'b0;
        dur_last   = dur_q - 1'b1;

        unique case (state_q)
            StIdle: begin
                note_d = NOTE_REST;
            end
            StFetch: begin
                state_d = StLoad;
            end
            StLoad: begin
                if (word_dur(rom_word) == DUR_END) begin
                    enter_end = 1'b1;
                end else begin
                    note_d  = word_note(rom_word);
                    dur_d   = word_dur(rom_word);
                    cyc_d   = '0;
                    tick_d  = '0;
                    state_d = StPlay;
                end
            end
            StPlay: begin
                if (tick_q == dur_last && cyc_q == TICK_LAST) begin
                    note_d = NOTE_REST;
                    cyc_d  = '0;
                    if (GAP_CYCLES != 0) begin
                        state_d = StGap;
                    end else begin
                        do_advance = 1'b1;
                    end
                end else if (cyc_q == TICK_LAST) begin
                    cyc_d  = '0;
                    tick_d = tick_q + 1'b1;
                end else begin
                    cyc_d = cyc_q + 1'b1;
                end
            end
            StGap: begin
                if (cyc_q == GAP_LAST) begin
                    do_advance = 1'b1;
                end else begin
                    cyc_d = cyc_q + 1'b1;
                end
            end
            StEnd: begin
                // done_q already carries the loop decision taken on entry.
                if (done_q) begin
                    state_d = StIdle;
                end else begin
                    addr_d  = '0;
                    state_d = StFetch;
                end
            end
            default: begin
                state_d = StIdle;
                note_d  = NOTE_REST;
            end
        endcase

        if (do_advance) begin
            if (addr_q == ADDR_LAST) begin
                enter_end = 1'b1;
            end else begin
                addr_d  = addr_q + 1'b1;
                state_d = StFetch;
            end
        end

        if (enter_end) begin
            state_d = StEnd;
            note_d  = NOTE_REST;
            done_d  = !loop;
        end

        if (start) begin
            state_d = StFetch;
            song_d  = song_sel;
            addr_d  = '0;
            note_d  = NOTE_REST;
            done_d  = 1'b0;
        end

        if (stop) begin
            state_d = StIdle;
            note_d  = NOTE_REST;
            done_d  = 1'b0;
        end
    end

    assign note = note_q;
    assign done = done_q;
    assign busy = (state_q != StIdle);

endmodule

// File: tb/tb_melody_sequencer.sv
// Self-checking bench for melody_sequencer: a queue-based song model predicts every output cycle,
// and hand-computed literal checks pin the model at key points of each scenario.
module tb_melody_sequencer;
    import melody_pkg::*;

    localparam int unsigned TICK    = 4;
    localparam int unsigned GAP     = 2;
    localparam int unsigned SONGS   = 4;
    localparam int unsigned ADDR_W  = 6;
    localparam int unsigned ENTRIES = 64;
    localparam int unsigned IMG_W   = SONGS * ENTRIES * WORD_W;

    function automatic logic [WORD_W-1:0] tb_word(input int s, input int i);
        logic [5:0] n;
        logic [3:0] d;
        n = 6'd0;
        d = 4'd0;
        case (s)
            0: case (i)
                   0: begin n = 6'd25; d = 4'd2; end
                   1: begin n = 6'd0;  d = 4'd1; end
                   2: begin n = 6'd32; d = 4'd3; end
                   default: ;
               endcase
            1: case (i)
                   0: begin n = 6'd40; d = 4'd1; end
                   1: begin n = 6'd41; d = 4'd2; end
                   default: ;
               endcase
            2: begin n = 6'((i % 62) + 1); d = 4'd1; end
            3: if (i == 0) begin n = 6'd63; d = 4'd1; end
            default: ;
        endcase
        return {n, d};
    endfunction

    function automatic logic [IMG_W-1:0] build_img();
        logic [IMG_W-1:0] img;
        img = '0;
        for (int s = 0; s < int'(SONGS); s++) begin
            for (int i = 0; i < int'(ENTRIES); i++) begin
                img[(s * ENTRIES + i) * WORD_W +: WORD_W] = tb_word(s, i);
            end
        end
        return img;
    endfunction

    localparam logic [IMG_W-1:0] ROM_IMG = build_img();

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start, stop, loop;
    logic [1:0] song_sel;
    logic [5:0] note;
    logic       busy, done;

    melody_sequencer #(
        .TICK_CYCLES (TICK),
        .GAP_CYCLES  (GAP),
        .SONGS       (SONGS),
        .ADDR_W      (ADDR_W),
        .SONG_W      (2),
        .ROM_INIT    (ROM_IMG)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .stop     (stop),
        .song_sel (song_sel),
        .loop     (loop),
        .note     (note),
        .busy     (busy),
        .done     (done)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    int done_cnt = 0;
    logic chk_en = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model: per-cycle expected output queue ----------------
    typedef struct packed {
        logic [5:0] note;
        logic       is_end;
    } item_t;

    item_t q[$];
    item_t it;
    int    mdl_song = 0;
    logic [5:0] exp_note = '0;
    logic       exp_busy = 1'b0;
    logic       exp_done = 1'b0;

    function automatic item_t mk(input logic [5:0] n, input logic e);
        item_t r;
        r.note   = n;
        r.is_end = e;
        return r;
    endfunction

    // Expected outputs for one pass of a song, starting with the FETCH cycle.
    task automatic push_song(input int s);
        logic [WORD_W-1:0] w;
        q.push_back(mk(6'd0, 1'b0));
        q.push_back(mk(6'd0, 1'b0));
        for (int i = 0; i < int'(ENTRIES); i++) begin
            w = tb_word(s, i);
            if (w[3:0] == 4'd0) begin
                q.push_back(mk(6'd0, 1'b1));
                return;
            end
            repeat (int'(w[3:0]) * TICK) q.push_back(mk(w[9:4], 1'b0));
            repeat (GAP) q.push_back(mk(6'd0, 1'b0));
            if (i == int'(ENTRIES) - 1) begin
                q.push_back(mk(6'd0, 1'b1));
            end else begin
                q.push_back(mk(6'd0, 1'b0));
                q.push_back(mk(6'd0, 1'b0));
            end
        end
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q.delete();
            mdl_song = 0;
            exp_note <= '0; exp_busy <= 1'b0; exp_done <= 1'b0;
        end else if (stop) begin
            q.delete();
            exp_note <= '0; exp_busy <= 1'b0; exp_done <= 1'b0;
        end else begin
            if (start) begin
                q.delete();
                mdl_song = int'(song_sel);
                push_song(mdl_song);
            end
            if (q.size() == 0) begin
                exp_note <= '0; exp_busy <= 1'b0; exp_done <= 1'b0;
            end else begin
                it = q.pop_front();
                exp_note <= it.note;
                exp_busy <= 1'b1;
                exp_done <= it.is_end && !loop;
                if (it.is_end && loop) push_song(mdl_song);
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("model_note", 32'(note), 32'(exp_note));
            check("model_busy", 32'(busy), 32'(exp_busy));
            check("model_done", 32'(done), 32'(exp_done));
            if (done === 1'b1) done_cnt++;
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse(input logic st, input logic sp, input logic [1:0] sel);
        @(negedge clk);
        start = st; stop = sp; song_sel = sel;
        @(negedge clk);
        start = 1'b0; stop = 1'b0;
    endtask

    int d0;

    initial begin
        rst_n = 1'b0; start = 1'b0; stop = 1'b0; loop = 1'b0; song_sel = 2'd0;
        wait_cyc(3);
        rst_n = 1'b1;
        chk_en = 1'b1;
        check("reset_note", 32'(note), 32'd0);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_done", 32'(done), 32'd0);

        // Basic song 0, no loop; times are cycles after the start edge.
        d0 = done_cnt;
        pulse(1'b1, 1'b0, 2'd0);
        check("basic_busy_k0", 32'(busy), 32'd1);
        check("basic_note_k0", 32'(note), 32'd0);
        wait_cyc(2);  check("basic_c4_first", 32'(note), 32'd25);
        wait_cyc(7);  check("basic_c4_last", 32'(note), 32'd25);
        wait_cyc(1);  check("basic_gap1", 32'(note), 32'd0);
        wait_cyc(12); check("basic_g4_first", 32'(note), 32'd32);
        wait_cyc(11); check("basic_g4_last", 32'(note), 32'd32);
        wait_cyc(1);  check("basic_after_g4", 32'(note), 32'd0);
        wait_cyc(4);  check("basic_done", 32'(done), 32'd1);
        check("basic_busy_done", 32'(busy), 32'd1);
        wait_cyc(1);  check("basic_idle_busy", 32'(busy), 32'd0);
        check("basic_done_once", 32'(done_cnt - d0), 32'd1);

        // Loop: second pass replays C4, then clearing loop ends after that pass.
        loop = 1'b1;
        d0 = done_cnt;
        pulse(1'b1, 1'b0, 2'd0);
        wait_cyc(38); check("loop_no_done", 32'(done), 32'd0);
        check("loop_busy_end", 32'(busy), 32'd1);
        wait_cyc(3);  check("loop_c4_again", 32'(note), 32'd25);
        loop = 1'b0;
        wait_cyc(36); check("loop_done_pass2", 32'(done), 32'd1);
        wait_cyc(1);  check("loop_idle", 32'(busy), 32'd0);
        check("loop_done_once", 32'(done_cnt - d0), 32'd1);

        // Stop during G4, then stop+start together.
        d0 = done_cnt;
        pulse(1'b1, 1'b0, 2'd0);
        wait_cyc(23); check("stop_pre_g4", 32'(note), 32'd32);
        pulse(1'b0, 1'b1, 2'd0);
        check("stop_note", 32'(note), 32'd0);
        check("stop_busy", 32'(busy), 32'd0);
        pulse(1'b1, 1'b0, 2'd0);
        wait_cyc(3);
        pulse(1'b1, 1'b1, 2'd1);
        check("stopstart_busy", 32'(busy), 32'd0);
        check("stopstart_note", 32'(note), 32'd0);
        wait_cyc(4);
        check("stop_no_done", 32'(done_cnt - d0), 32'd0);

        // Restart with song 1 while song 0 is playing.
        pulse(1'b1, 1'b0, 2'd0);
        wait_cyc(5);  check("restart_pre", 32'(note), 32'd25);
        pulse(1'b1, 1'b0, 2'd1);
        check("restart_silent", 32'(note), 32'd0);
        check("restart_busy", 32'(busy), 32'd1);
        wait_cyc(2);  check("restart_song1", 32'(note), 32'd40);
        wait_cyc(30);

        // Note 63 is passed through unchanged.
        pulse(1'b1, 1'b0, 2'd3);
        wait_cyc(2);  check("note63", 32'(note), 32'd63);
        wait_cyc(12);

        // Implicit end: 64 one-tick notes, no marker.
        pulse(1'b1, 1'b0, 2'd2);
        wait_cyc(2);   check("impl_first", 32'(note), 32'd1);
        wait_cyc(8);   check("impl_second", 32'(note), 32'd2);
        wait_cyc(502); check("impl_done", 32'(done), 32'd1);
        wait_cyc(1);   check("impl_idle", 32'(busy), 32'd0);

        // Asynchronous reset mid-note.
        pulse(1'b1, 1'b0, 2'd0);
        wait_cyc(3);
        #2 rst_n = 1'b0;
        #1;
        check("areset_note", 32'(note), 32'd0);
        check("areset_busy", 32'(busy), 32'd0);
        wait_cyc(2);
        rst_n = 1'b1;
        pulse(1'b1, 1'b0, 2'd0);
        wait_cyc(2);  check("post_reset_c4", 32'(note), 32'd25);
        wait_cyc(40);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
